// File: rtl/sevenseg_scan_decoder.sv
// sevenseg_scan_decoder: passive monitor for a multiplexed, active-low
// seven-segment display bus. It samples each digit once its anode and segment
// lines have been steady, decodes the pattern back to a nibble, and publishes
// the full word once every digit has been seen.
// Optional build macro SEVENSEG_SCAN_TIMEOUT_EN: discard a partial scan after
// TIMEOUT_CYCLES idle cycles and pulse scan_timeout.
module sevenseg_scan_decoder #(
    parameter int N_DIGITS       = 8,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_DIGITS-1:0]   anodes,
    input  logic [6:0]            segments,
    output logic [4*N_DIGITS-1:0] word,
    output logic                  word_valid,
    output logic [N_DIGITS-1:0]   err_mask,
    output logic                  scan_timeout
);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CW-1:0] SETTLE_V  = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] SETTLE_M1 = CW'(SETTLE_CYCLES - 1);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("sevenseg_scan_decoder: SETTLE_CYCLES or TIMEOUT_CYCLES out of range");
    end

    logic [N_DIGITS-1:0]   an_q;
    logic [6:0]            seg_q;
    logic [CW-1:0]         stable_cnt;
    logic                  captured;
    logic [N_DIGITS-1:0]   seen_mask;
    logic [N_DIGITS-1:0]   seen_next;
    logic [4*N_DIGITS-1:0] shadow_word;
    logic [N_DIGITS-1:0]   shadow_err;
    logic                  in_change;
    logic                  legal;
    logic [IW-1:0]         dig_idx;
    logic [3:0]            dec_nib;
    logic                  dec_err;
    logic                  capture;
    logic                  complete;
    logic                  timeout_hit;

    // A raw input that differs from the register means the registered pair changes this edge
    assign in_change = ({anodes, segments} != {an_q, seg_q});
    // Counter reaching SETTLE on this edge, legal anode, first time this interval
    assign capture   = !in_change && (stable_cnt >= SETTLE_M1) && legal && !captured;
    assign complete  = &seen_mask;

    // Single register stage on the display bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q  <= '0;
            seg_q <= '0;
        end else begin
            an_q  <= anodes;
            seg_q <= segments;
        end
    end

    // Exactly one low anode selects a digit; find which one
    always_comb begin
        legal   = $onehot(~an_q);
        dig_idx = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (!an_q[i]) dig_idx = IW'(i);
        end
    end

    // Inverse of the hex-to-segment encoder (abcdefg, active-low)
    always_comb begin
        dec_err = 1'b0;
        case (seg_q)
            7'b0000001: dec_nib = 4'h0;
            7'b1001111: dec_nib = 4'h1;
            7'b0010010: dec_nib = 4'h2;
            7'b0000110: dec_nib = 4'h3;
            7'b1001100: dec_nib = 4'h4;
            7'b0100100: dec_nib = 4'h5;
            7'b0100000: dec_nib = 4'h6;
            7'b0001111: dec_nib = 4'h7;
            7'b0000000: dec_nib = 4'h8;
            7'b0000100: dec_nib = 4'h9;
            7'b0001000: dec_nib = 4'hA;
            7'b1100000: dec_nib = 4'hB;
            7'b0110001: dec_nib = 4'hC;
            7'b1000010: dec_nib = 4'hD;
            7'b0110000: dec_nib = 4'hE;
            7'b0111000: dec_nib = 4'hF;
            default: begin
                dec_nib = 4'h0;
                dec_err = 1'b1;
            end
        endcase
    end

    // Stability counter and once-per-interval capture flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_cnt <= '0;
            captured   <= 1'b0;
        end else if (in_change) begin
            stable_cnt <= '0;
            captured   <= 1'b0;
        end else begin
            if (stable_cnt != SETTLE_V) stable_cnt <= stable_cnt + CW'(1);
            if (!legal)       captured <= 1'b0;
            else if (capture) captured <= 1'b1;
        end
    end

    // Completion/timeout clear first so a same-edge capture starts the next scan
    always_comb begin
        seen_next = seen_mask;
        if (complete || timeout_hit) seen_next = '0;
        if (capture) seen_next[dig_idx] = 1'b1;
    end

    // Shadow word and seen mask; latest capture of a digit wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_mask   <= '0;
            shadow_word <= '0;
            shadow_err  <= '0;
        end else begin
            seen_mask <= seen_next;
            if (capture) begin
                shadow_word[4*dig_idx +: 4] <= dec_nib;
                shadow_err[dig_idx]         <= dec_err;
            end
        end
    end

    // Publish the word one edge after the scan is complete
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word       <= '0;
            err_mask   <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= complete;
            if (complete) begin
                word     <= shadow_word;
                err_mask <= shadow_err;
            end
        end
    end

`ifdef SEVENSEG_SCAN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt;

    // A capture on the same edge always beats the timeout
    assign timeout_hit = !capture && !complete && (seen_mask != '0) &&
                         (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Idle counter runs only while a partial scan is pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt     <= '0;
            scan_timeout <= 1'b0;
        end else begin
            scan_timeout <= timeout_hit;
            if (capture || timeout_hit || seen_mask == '0) idle_cnt <= '0;
            else                                           idle_cnt <= idle_cnt + TW'(1);
        end
    end
`else
    assign timeout_hit  = 1'b0;
    assign scan_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Bench for sevenseg_scan_decoder: directed scenarios plus randomized scans,
// checked against a transaction-level model of the display protocol.
module tb_sevenseg_scan_decoder;
    localparam int ND     = 8;
    localparam int SETTLE = 4;
    localparam int TMO    = 100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [ND-1:0] anodes = '1;
    logic [6:0]    segments = '1;
    logic [4*ND-1:0] word;
    logic          word_valid;
    logic [ND-1:0] err_mask;
    logic          scan_timeout;

    sevenseg_scan_decoder #(
        .N_DIGITS(ND), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .anodes(anodes), .segments(segments),
        .word(word), .word_valid(word_valid), .err_mask(err_mask),
        .scan_timeout(scan_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nchk = 0, nerr = 0, npulse = 0, nto = 0;

    typedef struct {
        logic [31:0] w;
        logic [7:0]  e;
        int          c;
    } exp_t;
    exp_t expq[$];

    // model state
    logic [6:0]  enc_tab [16];
    logic [3:0]  m_nib [ND];
    logic        m_err [ND];
    logic [ND-1:0] m_seen;
    logic [14:0] run_val;
    int          run_len, run_start;
    bit          run_cap, fresh;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] sel(int i);
        return ~(8'd1 << i);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ND; i++) begin
            m_nib[i] = 4'h0;
            m_err[i] = 1'b0;
        end
        m_seen = '0;
        fresh  = 1'b1;
    endtask

    // A stable legal digit decodes by looking it up in the encoder table
    task automatic model_capture(logic [7:0] an, logic [6:0] sg, int pulse_cyc);
        int   idx, lows;
        logic [3:0]  nib;
        logic        e;
        logic [31:0] w;
        logic [7:0]  em;
        idx = 0; lows = 0;
        for (int i = 0; i < ND; i++) if (!an[i]) begin lows++; idx = i; end
        if (lows != 1) return;
        nib = 4'h0; e = 1'b1;
        for (int v = 0; v < 16; v++) if (enc_tab[v] == sg) begin nib = 4'(v); e = 1'b0; end
        m_nib[idx] = nib; m_err[idx] = e; m_seen[idx] = 1'b1;
        if (&m_seen) begin
            for (int i = 0; i < ND; i++) begin
                w[4*i +: 4] = m_nib[i];
                em[i] = m_err[i];
            end
            expq.push_back('{w: w, e: em, c: pulse_cyc});
            m_seen = '0;
        end
    endtask

    // Hold a bus value for n cycles; a value held SETTLE+1 edges is captured once
    task automatic drive(logic [7:0] an, logic [6:0] sg, int n);
        anodes = an; segments = sg;
        if (fresh || {an, sg} != run_val) begin
            run_val = {an, sg}; run_len = 0; run_cap = 0; run_start = cyc; fresh = 0;
        end
        if (!run_cap && run_len + n >= SETTLE + 1) begin
            run_cap = 1;
            model_capture(an, sg, run_start + SETTLE + 2);
        end
        run_len += n;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(logic [31:0] w, int hold);
        for (int i = 0; i < ND; i++) drive(sel(i), enc_tab[w[4*i +: 4]], hold);
        drive(8'hFF, 7'h7F, 4);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; anodes = '1; segments = '1;
        @(negedge clk); @(negedge clk);
        chk("rst_word", word, 0);
        chk("rst_valid", word_valid, 0);
        chk("rst_err", err_mask, 0);
        chk("rst_timeout", scan_timeout, 0);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Every word_valid pulse must match the next modelled word, at the modelled cycle
    always @(negedge clk) begin
        exp_t x;
        if (rst_n) begin
            if (scan_timeout) nto++;
            if (word_valid) begin
                npulse++;
                if (expq.size() == 0) chk("spurious_valid", 1, 0);
                else begin
                    x = expq.pop_front();
                    chk("word", word, x.w);
                    chk("err_mask", err_mask, x.e);
                    chk("latency", cyc, x.c);
                end
            end
        end
    end

    initial begin
        int p0, t0, order[8], j, tmp, k;
        logic [31:0] w;
        logic [6:0]  sg;
        enc_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        model_reset();
        @(negedge clk);
        do_reset();

        // full scan in order
        p0 = npulse;
        scan(32'hDEADBEEF, 8);
        chk("deadbeef_pulses", npulse - p0, 1);
        chk("deadbeef_word", word, 32'hDEADBEEF);
        chk("deadbeef_err", err_mask, 0);

        // glitch on digit 3 must not complete the scan
        w = 32'h12345678; p0 = npulse;
        for (int i = 0; i < ND; i++) drive(sel(i), enc_tab[w[4*i +: 4]], (i == 3) ? SETTLE - 1 : 8);
        drive(8'hFF, 7'h7F, 4);
        chk("glitch_nopulse", npulse - p0, 0);
        drive(sel(3), enc_tab[w[15:12]], 8);
        drive(8'hFF, 7'h7F, 4);
        chk("glitch_pulses", npulse - p0, 1);
        chk("glitch_word", word, 32'h12345678);

        // undecodable pattern on digit 5
        for (int i = 0; i < ND; i++) drive(sel(i), (i == 5) ? 7'h7F : enc_tab[0], 8);
        drive(8'hFF, 7'h7F, 4);
        chk("invalid_word", word, 0);
        chk("invalid_err", err_mask, 8'b00100000);

        // multi-low anodes are ignored
        p0 = npulse;
        drive(8'hFC, enc_tab[3], 20);
        scan(32'hCAFE0123, 8);
        chk("illegal_pulses", npulse - p0, 1);
        chk("illegal_word", word, 32'hCAFE0123);

        // reset in the middle of a scan
        w = 32'h89ABCDEF;
        for (int i = 0; i < 5; i++) drive(sel(i), enc_tab[w[4*i +: 4]], 8);
        do_reset();
        p0 = npulse;
        scan(32'h00000001, 8);
        chk("rstmid_pulses", npulse - p0, 1);
        chk("rstmid_word", word, 32'h1);

        // randomized scans: shuffled order, glitches, blanking, stray anodes, bad patterns
        for (int r = 0; r < 14; r++) begin
            w = $urandom;
            for (int i = 0; i < 8; i++) order[i] = i;
            for (int i = 7; i > 0; i--) begin
                j = $urandom_range(0, i); tmp = order[i]; order[i] = order[j]; order[j] = tmp;
            end
            for (int n = 0; n < 8; n++) begin
                k = order[n];
                case ($urandom_range(0, 9))
                    0: drive(sel(k), enc_tab[$urandom_range(0, 15)], $urandom_range(1, SETTLE));
                    1: drive(8'hFF, 7'h7F, $urandom_range(1, 6));
                    2: drive(8'($urandom), enc_tab[$urandom_range(0, 15)], $urandom_range(1, 10));
                    default: ;
                endcase
                sg = ($urandom_range(0, 7) == 0) ? 7'($urandom) : enc_tab[w[4*k +: 4]];
                drive(sel(k), sg, $urandom_range(SETTLE - 1, SETTLE + 6));
            end
        end
        drive(8'hFF, 7'h7F, 6);
        do_reset();

        // partial scan followed by a long idle period
        w = 32'hA5C3961E; p0 = npulse; t0 = nto;
        for (int i = 0; i < 3; i++) drive(sel(i), enc_tab[w[4*i +: 4]], 8);
        drive(8'hFF, 7'h7F, TMO + 20);
`ifdef SEVENSEG_SCAN_TIMEOUT_EN
        chk("timeout_pulses", nto - t0, 1);
        chk("timeout_word_held", word, 0);
        m_seen = '0;
        scan(32'h0F1E2D3C, 8);
        chk("after_timeout_word", word, 32'h0F1E2D3C);
`else
        chk("no_timeout", nto - t0, 0);
        chk("partial_held", npulse - p0, 0);
        for (int i = 3; i < ND; i++) drive(sel(i), enc_tab[w[4*i +: 4]], 8);
        drive(8'hFF, 7'h7F, 4);
        chk("partial_done_word", word, 32'hA5C3961E);
`endif
        chk("pending_words", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end
endmodule
